// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin CPU/video sharing of one 32-bit async SRAM with programmable strobe timing
//   clk, rst                                   clock, synchronous active-high reset
//   cpu_req/we/be/adr/wdat -> cpu_rdat/ack     CPU read/write port, level request, one-cycle ack
//   vid_req/adr -> vid_rdat/ack                video read-only port, same handshake
//   SRce0/SRce1/SRwe/SRoe/SRbe/SRadr/SRdat     registered SRAM pins, SRdat driven only in write states
module sram_arbiter #(
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_be,
    input  logic [17:0] cpu_adr,
    input  logic [31:0] cpu_wdat,
    output logic [31:0] cpu_rdat,
    output logic        cpu_ack,
    input  logic        vid_req,
    input  logic [17:0] vid_adr,
    output logic [31:0] vid_rdat,
    output logic        vid_ack,
    output logic        SRce0,
    output logic        SRce1,
    output logic        SRwe,
    output logic        SRoe,
    output logic [3:0]  SRbe,
    output logic [17:0] SRadr,
    inout  wire  [31:0] SRdat
);
    typedef enum logic [2:0] {IDLE, READ, WSETUP, WPULSE, WHOLD} state_t;
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        last_vid_q, sel_vid_q, drive_q;
    logic [31:0] wdat_q;
    logic        cpu_elig, vid_elig, pick_vid;
    // a port whose ack is high this cycle is not re-granted; ties go to the port not served last
    always_comb begin
        cpu_elig = cpu_req && !cpu_ack;
        vid_elig = vid_req && !vid_ack;
        pick_vid = vid_elig && (!cpu_elig || !last_vid_q);
    end
    assign SRdat = drive_q ? wdat_q : 'z;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_vid_q <= 1'b1;
            sel_vid_q  <= 1'b0;
            drive_q    <= 1'b0;
            wdat_q     <= '0;
            cpu_ack    <= 1'b0;
            vid_ack    <= 1'b0;
            cpu_rdat   <= '0;
            vid_rdat   <= '0;
            SRce0      <= 1'b1;
            SRce1      <= 1'b1;
            SRwe       <= 1'b1;
            SRoe       <= 1'b1;
            SRbe       <= 4'hF;
            SRadr      <= '0;
        end else begin
            cpu_ack <= 1'b0;
            vid_ack <= 1'b0;
            case (state_q)
                IDLE: if (cpu_elig || vid_elig) begin
                    sel_vid_q  <= pick_vid;
                    last_vid_q <= pick_vid;
                    SRadr      <= pick_vid ? vid_adr : cpu_adr;
                    SRce0      <= 1'b0;
                    SRce1      <= 1'b0;
                    if (!pick_vid && cpu_we) begin
                        state_q <= WSETUP;
                        SRbe    <= ~cpu_be;
                        wdat_q  <= cpu_wdat;
                        drive_q <= 1'b1;
                    end else begin
                        state_q <= READ;
                        SRoe    <= 1'b0;
                        SRbe    <= 4'h0;
                        cnt_q   <= 4'(RD_CYCLES - 1);
                    end
                end
                READ: if (cnt_q == 4'd0) begin
                    state_q <= IDLE;
                    SRoe    <= 1'b1;
                    SRce0   <= 1'b1;
                    SRce1   <= 1'b1;
                    SRbe    <= 4'hF;
                    if (sel_vid_q) begin
                        vid_rdat <= SRdat;
                        vid_ack  <= 1'b1;
                    end else begin
                        cpu_rdat <= SRdat;
                        cpu_ack  <= 1'b1;
                    end
                end else cnt_q <= cnt_q - 4'd1;
                WSETUP: begin
                    state_q <= WPULSE;
                    SRwe    <= 1'b0;
                    cnt_q   <= 4'(WR_CYCLES - 1);
                end
                WPULSE: if (cnt_q == 4'd0) begin
                    state_q <= WHOLD;
                    SRwe    <= 1'b1;
                    cpu_ack <= 1'b1;
                end else cnt_q <= cnt_q - 4'd1;
                WHOLD: begin
                    state_q <= IDLE;
                    SRce0   <= 1'b1;
                    SRce1   <= 1'b1;
                    SRbe    <= 4'hF;
                    drive_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
